// File: rtl/uarch_pkg.sv
// rtl/uarch_pkg.sv - store queue sizes, entry/request types and pointer window helper
package uarch_pkg;

  localparam int PIPE_WIDTH    = 2;
  localparam int TAG_WIDTH     = 6;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_DATA_BITS = 32;
  localparam int SQ_DEPTH      = 8;
  localparam int SQ_IDX        = $clog2(SQ_DEPTH);

  typedef logic [SQ_IDX:0]   sq_ptr_t;
  typedef logic [SQ_IDX-1:0] sq_idx_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]     rob_tag;
    logic [CPU_ADDR_BITS-1:0] addr;
    logic [CPU_DATA_BITS-1:0] data;
    logic [3:0]               be;
    logic                     resolved;
    logic                     committed;
    logic                     valid;
  } sq_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [CPU_ADDR_BITS-1:0] addr;
    logic [CPU_DATA_BITS-1:0] data;
    logic [3:0]               be;
  } dmem_store_req_t;

  // True when slot idx lies in the circular window [lo, hi) of wrap-bit pointers
  function automatic logic in_window(input sq_idx_t idx, input sq_ptr_t lo, input sq_ptr_t hi);
    sq_idx_t off;
    sq_ptr_t span;
    off  = idx - lo[SQ_IDX-1:0];
    span = hi - lo;
    return ({1'b0, off} < span);
  endfunction

endpackage

// File: rtl/sq_tag_cam.sv
// rtl/sq_tag_cam.sv - ROB tag match across store queue entries, one-hot hit vector
module sq_tag_cam
  import uarch_pkg::*;
(
  input  logic                                en,
  input  logic [TAG_WIDTH-1:0]                tag,
  input  logic [SQ_DEPTH-1:0][TAG_WIDTH-1:0]  entry_tags,
  input  logic [SQ_DEPTH-1:0]                 candidate,
  output logic [SQ_DEPTH-1:0]                 hit
);

  // Compare the searched tag against every candidate entry in parallel
  always_comb begin
    hit = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      hit[i] = en && candidate[i] && (entry_tags[i] == tag);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue, optional load forwarding under STORE_BUFFER_FWD_EN
module store_buffer
  import uarch_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [PIPE_WIDTH-1:0]                sq_alloc_req,
  input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] sq_alloc_rob_tags,
  output logic [1:0]                           sq_rdy,
  output logic [PIPE_WIDTH-1:0][SQ_IDX-1:0]    sq_alloc_ids,
  input  logic                                 st_exec_valid,
  input  logic [TAG_WIDTH-1:0]                 st_exec_rob_tag,
  input  logic [CPU_ADDR_BITS-1:0]             st_exec_addr,
  input  logic [CPU_DATA_BITS-1:0]             st_exec_data,
  input  logic [3:0]                           st_exec_be,
  input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] commit_store_ids,
  input  logic [PIPE_WIDTH-1:0]                commit_store_vals,
  output logic                                 dmem_req_valid,
  output logic [CPU_ADDR_BITS-1:0]             dmem_req_addr,
  output logic [CPU_DATA_BITS-1:0]             dmem_req_data,
  output logic [3:0]                           dmem_req_be,
  input  logic                                 dmem_req_ready,
  output logic                                 sq_empty,
  output logic [SQ_IDX:0]                      sq_count
`ifdef STORE_BUFFER_FWD_EN
  ,
  input  logic                                 ld_fwd_valid,
  input  logic [CPU_ADDR_BITS-1:0]             ld_fwd_addr,
  output logic                                 ld_fwd_hit,
  output logic [CPU_DATA_BITS-1:0]             ld_fwd_data,
  output logic                                 ld_fwd_conflict
`endif
);

  sq_entry_t                          entries_q [SQ_DEPTH];
  sq_entry_t                          entries_d [SQ_DEPTH];
  sq_ptr_t                            head_q, head_d;
  sq_ptr_t                            cmt_q, cmt_d;
  sq_ptr_t                            tail_q, tail_d;
  sq_ptr_t                            count;
  sq_ptr_t                            free_cnt;
  sq_ptr_t                            n_acc;
  sq_entry_t                          head_entry;
  dmem_store_req_t                    dmem_req;
  logic                               drain_fire;
  logic [SQ_DEPTH-1:0][TAG_WIDTH-1:0] entry_tags;
  logic [SQ_DEPTH-1:0]                res_candidate;
  logic [SQ_DEPTH-1:0]                res_hit;
  sq_idx_t                            cmt_second_idx;

  assign count    = tail_q - head_q;
  assign free_cnt = sq_ptr_t'(SQ_DEPTH) - count;
  assign sq_count = count;
  assign sq_empty = (count == '0);
  assign sq_rdy   = {free_cnt >= sq_ptr_t'(2), free_cnt >= sq_ptr_t'(1)};

  // Offer the next free indices in compacted slot order
  always_comb begin
    sq_alloc_ids = '0;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      sq_alloc_ids[k] = tail_q[SQ_IDX-1:0] + sq_idx_t'(k);
    end
  end

  // Drain port shows the oldest entry once it is both resolved and committed
  always_comb begin
    head_entry = entries_q[head_q[SQ_IDX-1:0]];
    dmem_req   = '0;
    if (head_entry.valid && head_entry.resolved && head_entry.committed) begin
      dmem_req.valid = 1'b1;
      dmem_req.addr  = head_entry.addr & ~CPU_ADDR_BITS'(3);
      dmem_req.data  = head_entry.data;
      dmem_req.be    = head_entry.be;
    end
  end

  assign dmem_req_valid = dmem_req.valid;
  assign dmem_req_addr  = dmem_req.addr;
  assign dmem_req_data  = dmem_req.data;
  assign dmem_req_be    = dmem_req.be;
  assign drain_fire     = dmem_req.valid && dmem_req_ready;

  // Resolve candidates: allocated, not yet resolved, and inside [cmt, tail)
  always_comb begin
    entry_tags    = '0;
    res_candidate = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      entry_tags[i]    = entries_q[i].rob_tag;
      res_candidate[i] = entries_q[i].valid && !entries_q[i].resolved &&
                         in_window(sq_idx_t'(i), cmt_q, tail_q);
    end
  end

  sq_tag_cam u_res_cam (
    .en         (st_exec_valid),
    .tag        (st_exec_rob_tag),
    .entry_tags (entry_tags),
    .candidate  (res_candidate),
    .hit        (res_hit)
  );

  // Next state: drain, resolve, commit, then either flush rollback or allocation
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    cmt_d     = cmt_q;
    tail_d    = tail_q;
    n_acc     = '0;

    if (drain_fire) begin
      entries_d[head_q[SQ_IDX-1:0]] = '0;
      head_d = head_q + 1'b1;
    end

    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (res_hit[i]) begin
        entries_d[i].addr     = st_exec_addr;
        entries_d[i].data     = st_exec_data;
        entries_d[i].be       = st_exec_be;
        entries_d[i].resolved = 1'b1;
      end
    end

    for (int k = 0; k < PIPE_WIDTH; k++) begin
      if (commit_store_vals[k]) begin
        entries_d[cmt_d[SQ_IDX-1:0]].committed = 1'b1;
        cmt_d = cmt_d + 1'b1;
      end
    end

    if (flush) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (in_window(sq_idx_t'(i), cmt_d, tail_q)) begin
          entries_d[i] = '0;
        end
      end
      tail_d = cmt_d;
    end else begin
      for (int k = 0; k < PIPE_WIDTH; k++) begin
        if (sq_alloc_req[k] && (n_acc < free_cnt)) begin
          entries_d[tail_d[SQ_IDX-1:0]]         = '0;
          entries_d[tail_d[SQ_IDX-1:0]].valid   = 1'b1;
          entries_d[tail_d[SQ_IDX-1:0]].rob_tag = sq_alloc_rob_tags[k];
          tail_d = tail_d + 1'b1;
          n_acc  = n_acc + 1'b1;
        end
      end
    end
  end

  // Pointer and entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      cmt_q     <= cmt_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

  assign cmt_second_idx = cmt_q[SQ_IDX-1:0] + sq_idx_t'(commit_store_vals[0]);

  // A retiring store must be the one the ROB names; the entry is committed either way
  always_ff @(posedge clk) begin
    if (!rst && commit_store_vals[0]) begin
      assert (entries_q[cmt_q[SQ_IDX-1:0]].rob_tag == commit_store_ids[0]);
    end
    if (!rst && commit_store_vals[1]) begin
      assert (entries_q[cmt_second_idx].rob_tag == commit_store_ids[1]);
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  // Youngest committed store to the same word decides: full-word hit or partial conflict
  always_comb begin
    sq_entry_t sel;
    logic      found;
    sq_idx_t   idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      idx = head_q[SQ_IDX-1:0] + sq_idx_t'(k);
      if (in_window(idx, head_q, cmt_q) && entries_q[idx].valid &&
          entries_q[idx].committed && entries_q[idx].resolved &&
          (((entries_q[idx].addr ^ ld_fwd_addr) & ~CPU_ADDR_BITS'(3)) == '0)) begin
        sel   = entries_q[idx];
        found = 1'b1;
      end
    end
    ld_fwd_hit      = ld_fwd_valid && found && (sel.be == 4'hF);
    ld_fwd_conflict = ld_fwd_valid && found && (sel.be != 4'hF);
    ld_fwd_data     = ld_fwd_hit ? sel.data : '0;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
  import uarch_pkg::*;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic                                 flush;
  logic [PIPE_WIDTH-1:0]                sq_alloc_req;
  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] sq_alloc_rob_tags;
  logic [1:0]                           sq_rdy;
  logic [PIPE_WIDTH-1:0][SQ_IDX-1:0]    sq_alloc_ids;
  logic                                 st_exec_valid;
  logic [TAG_WIDTH-1:0]                 st_exec_rob_tag;
  logic [CPU_ADDR_BITS-1:0]             st_exec_addr;
  logic [CPU_DATA_BITS-1:0]             st_exec_data;
  logic [3:0]                           st_exec_be;
  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] commit_store_ids;
  logic [PIPE_WIDTH-1:0]                commit_store_vals;
  logic                                 dmem_req_valid;
  logic [CPU_ADDR_BITS-1:0]             dmem_req_addr;
  logic [CPU_DATA_BITS-1:0]             dmem_req_data;
  logic [3:0]                           dmem_req_be;
  logic                                 dmem_req_ready;
  logic                                 sq_empty;
  logic [SQ_IDX:0]                      sq_count;
`ifdef STORE_BUFFER_FWD_EN
  logic                                 ld_fwd_valid;
  logic [CPU_ADDR_BITS-1:0]             ld_fwd_addr;
  logic                                 ld_fwd_hit;
  logic [CPU_DATA_BITS-1:0]             ld_fwd_data;
  logic                                 ld_fwd_conflict;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .sq_alloc_req      (sq_alloc_req),
    .sq_alloc_rob_tags (sq_alloc_rob_tags),
    .sq_rdy            (sq_rdy),
    .sq_alloc_ids      (sq_alloc_ids),
    .st_exec_valid     (st_exec_valid),
    .st_exec_rob_tag   (st_exec_rob_tag),
    .st_exec_addr      (st_exec_addr),
    .st_exec_data      (st_exec_data),
    .st_exec_be        (st_exec_be),
    .commit_store_ids  (commit_store_ids),
    .commit_store_vals (commit_store_vals),
    .dmem_req_valid    (dmem_req_valid),
    .dmem_req_addr     (dmem_req_addr),
    .dmem_req_data     (dmem_req_data),
    .dmem_req_be       (dmem_req_be),
    .dmem_req_ready    (dmem_req_ready),
    .sq_empty          (sq_empty),
    .sq_count          (sq_count)
`ifdef STORE_BUFFER_FWD_EN
    ,
    .ld_fwd_valid      (ld_fwd_valid),
    .ld_fwd_addr       (ld_fwd_addr),
    .ld_fwd_hit        (ld_fwd_hit),
    .ld_fwd_data       (ld_fwd_data),
    .ld_fwd_conflict   (ld_fwd_conflict)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush             = 1'b0;
    sq_alloc_req      = '0;
    sq_alloc_rob_tags = '0;
    st_exec_valid     = 1'b0;
    st_exec_rob_tag   = '0;
    st_exec_addr      = '0;
    st_exec_data      = '0;
    st_exec_be        = '0;
    commit_store_ids  = '0;
    commit_store_vals = '0;
    dmem_req_ready    = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    ld_fwd_valid      = 1'b0;
    ld_fwd_addr       = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] req, input logic [TAG_WIDTH-1:0] t0, input logic [TAG_WIDTH-1:0] t1);
    sq_alloc_req         = req;
    sq_alloc_rob_tags[0] = t0;
    sq_alloc_rob_tags[1] = t1;
    tick();
    sq_alloc_req = '0;
  endtask

  task automatic resolve(input logic [TAG_WIDTH-1:0] tag, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    st_exec_valid   = 1'b1;
    st_exec_rob_tag = tag;
    st_exec_addr    = addr;
    st_exec_data    = data;
    st_exec_be      = be;
    tick();
    st_exec_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sq_rdy !== 2'b11) begin n_bad++; $display("FAIL reset_rdy: got %b want 11", sq_rdy); end
    n_cmp++; if (sq_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", sq_empty); end
    n_cmp++; if (sq_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", sq_count); end
    n_cmp++; if (dmem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", dmem_req_valid); end
    n_cmp++; if (dmem_req_addr !== 32'h0 || dmem_req_data !== 32'h0 || dmem_req_be !== 4'h0) begin
      n_bad++; $display("FAIL reset_payload: got %h/%h/%h want 0/0/0", dmem_req_addr, dmem_req_data, dmem_req_be); end
    n_cmp++; if (sq_alloc_ids !== {3'd1, 3'd0}) begin n_bad++; $display("FAIL reset_ids: got %h want %h", sq_alloc_ids, {3'd1, 3'd0}); end
  endtask

  task automatic test_drain_in_order();
    do_reset();
    alloc(2'b11, 6'd3, 6'd4);
    n_cmp++; if (sq_count !== 4'd2) begin n_bad++; $display("FAIL drain_alloc_count: got %0d want 2", sq_count); end
    n_cmp++; if (sq_alloc_ids !== {3'd3, 3'd2}) begin n_bad++; $display("FAIL drain_alloc_ids: got %h want %h", sq_alloc_ids, {3'd3, 3'd2}); end
    resolve(6'd4, 32'h104, 32'hBBBBBBBB, 4'hF);
    resolve(6'd3, 32'h100, 32'hAAAAAAAA, 4'hF);
    n_cmp++; if (dmem_req_valid !== 1'b0) begin n_bad++; $display("FAIL drain_uncommitted: got valid %b want 0", dmem_req_valid); end
    commit_store_ids[0] = 6'd3;
    commit_store_ids[1] = 6'd4;
    commit_store_vals   = 2'b11;
    dmem_req_ready      = 1'b1;
    tick();
    commit_store_vals = '0;
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h100 || dmem_req_data !== 32'hAAAAAAAA) begin
      n_bad++; $display("FAIL drain_first: got %b %h %h want 1 100 aaaaaaaa", dmem_req_valid, dmem_req_addr, dmem_req_data); end
    tick();
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h104 || dmem_req_data !== 32'hBBBBBBBB) begin
      n_bad++; $display("FAIL drain_second: got %b %h %h want 1 104 bbbbbbbb", dmem_req_valid, dmem_req_addr, dmem_req_data); end
    tick();
    n_cmp++; if (dmem_req_valid !== 1'b0 || sq_empty !== 1'b1) begin
      n_bad++; $display("FAIL drain_done: got valid %b empty %b want 0 1", dmem_req_valid, sq_empty); end
    dmem_req_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(2'b11, 6'(10 + 2 * i), 6'(11 + 2 * i));
    end
    n_cmp++; if (sq_count !== 4'd8 || sq_rdy !== 2'b00) begin
      n_bad++; $display("FAIL full_count_rdy: got %0d %b want 8 00", sq_count, sq_rdy); end
    n_cmp++; if (sq_alloc_ids !== {3'd1, 3'd0}) begin n_bad++; $display("FAIL full_ids: got %h want %h", sq_alloc_ids, {3'd1, 3'd0}); end
    resolve(6'd10, 32'h300, 32'h30, 4'hF);
    resolve(6'd11, 32'h304, 32'h31, 4'hF);
    commit_store_ids[0] = 6'd10;
    commit_store_ids[1] = 6'd11;
    commit_store_vals   = 2'b11;
    tick();
    commit_store_vals = '0;
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h300 || sq_count !== 4'd8) begin
      n_bad++; $display("FAIL full_head_ready: got %b %h %0d want 1 300 8", dmem_req_valid, dmem_req_addr, sq_count); end
    dmem_req_ready = 1'b1;
    alloc(2'b11, 6'd18, 6'd19);
    n_cmp++; if (sq_count !== 4'd7 || sq_rdy !== 2'b01 || dmem_req_addr !== 32'h304) begin
      n_bad++; $display("FAIL full_alloc_drain: got %0d %b %h want 7 01 304", sq_count, sq_rdy, dmem_req_addr); end
    alloc(2'b01, 6'd18, 6'd0);
    n_cmp++; if (sq_count !== 4'd7) begin n_bad++; $display("FAIL full_refill_one: got %0d want 7", sq_count); end
    dmem_req_ready = 1'b0;
    alloc(2'b01, 6'd19, 6'd0);
    n_cmp++; if (sq_count !== 4'd8 || sq_rdy !== 2'b00 || dmem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL full_refill_two: got %0d %b %b want 8 00 0", sq_count, sq_rdy, dmem_req_valid); end
    n_cmp++; if (sq_alloc_ids !== {3'd3, 3'd2}) begin n_bad++; $display("FAIL wrap_ids: got %h want %h", sq_alloc_ids, {3'd3, 3'd2}); end
  endtask

  task automatic test_flush_and_stale();
    do_reset();
    alloc(2'b11, 6'd20, 6'd21);
    alloc(2'b11, 6'd22, 6'd23);
    resolve(6'd20, 32'h400, 32'h44444444, 4'hF);
    flush                = 1'b1;
    commit_store_ids[0]  = 6'd20;
    commit_store_vals    = 2'b01;
    sq_alloc_req         = 2'b11;
    sq_alloc_rob_tags[0] = 6'd30;
    sq_alloc_rob_tags[1] = 6'd31;
    tick();
    flush             = 1'b0;
    commit_store_vals = '0;
    sq_alloc_req      = '0;
    n_cmp++; if (sq_count !== 4'd1 || sq_alloc_ids !== {3'd2, 3'd1}) begin
      n_bad++; $display("FAIL flush_count: got %0d ids %h want 1 ids %h", sq_count, sq_alloc_ids, {3'd2, 3'd1}); end
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h400) begin
      n_bad++; $display("FAIL flush_survivor: got %b %h want 1 400", dmem_req_valid, dmem_req_addr); end
    resolve(6'd21, 32'h500, 32'h55555555, 4'hF);
    n_cmp++; if (sq_count !== 4'd1 || dmem_req_addr !== 32'h400 || dmem_req_data !== 32'h44444444) begin
      n_bad++; $display("FAIL stale_resolve: got %0d %h %h want 1 400 44444444", sq_count, dmem_req_addr, dmem_req_data); end
    dmem_req_ready = 1'b1;
    tick();
    n_cmp++; if (sq_empty !== 1'b1 || dmem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_drained: got empty %b valid %b want 1 0", sq_empty, dmem_req_valid); end
    dmem_req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc(2'b01, 6'd5, 6'd0);
    st_exec_valid       = 1'b1;
    st_exec_rob_tag     = 6'd5;
    st_exec_addr        = 32'h603;
    st_exec_data        = 32'h66666666;
    st_exec_be          = 4'h3;
    commit_store_ids[0] = 6'd5;
    commit_store_vals   = 2'b01;
    tick();
    st_exec_valid     = 1'b0;
    commit_store_vals = '0;
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h600 || dmem_req_data !== 32'h66666666 || dmem_req_be !== 4'h3) begin
      n_bad++; $display("FAIL bp_same_cycle: got %b %h %h %h want 1 600 66666666 3", dmem_req_valid, dmem_req_addr, dmem_req_data, dmem_req_be); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h600 || dmem_req_data !== 32'h66666666 || sq_count !== 4'd1) begin
        n_bad++; $display("FAIL bp_hold%0d: got %b %h %h %0d want 1 600 66666666 1", c, dmem_req_valid, dmem_req_addr, dmem_req_data, sq_count); end
    end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    n_cmp++; if (dmem_req_valid !== 1'b0 || sq_count !== 4'd0) begin
      n_bad++; $display("FAIL bp_release: got %b %0d want 0 0", dmem_req_valid, sq_count); end
  endtask

  task automatic test_reset_mid_drain();
    alloc(2'b01, 6'd7, 6'd0);
    st_exec_valid       = 1'b1;
    st_exec_rob_tag     = 6'd7;
    st_exec_addr        = 32'h700;
    st_exec_data        = 32'h77777777;
    st_exec_be          = 4'hF;
    commit_store_ids[0] = 6'd7;
    commit_store_vals   = 2'b01;
    tick();
    st_exec_valid     = 1'b0;
    commit_store_vals = '0;
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h700) begin
      n_bad++; $display("FAIL rmd_pending: got %b %h want 1 700", dmem_req_valid, dmem_req_addr); end
    rst = 1'b1;
    dmem_req_ready = 1'b1;
    tick();
    rst = 1'b0;
    dmem_req_ready = 1'b0;
    n_cmp++; if (dmem_req_valid !== 1'b0 || sq_count !== 4'd0 || dmem_req_addr !== 32'h0) begin
      n_bad++; $display("FAIL rmd_dropped: got %b %0d %h want 0 0 0", dmem_req_valid, sq_count, dmem_req_addr); end
  endtask

`ifdef STORE_BUFFER_FWD_EN
  task automatic test_forward();
    do_reset();
    alloc(2'b11, 6'd1, 6'd2);
    resolve(6'd1, 32'h200, 32'h11111111, 4'hF);
    resolve(6'd2, 32'h200, 32'h22222222, 4'hF);
    commit_store_ids[0] = 6'd1;
    commit_store_ids[1] = 6'd2;
    commit_store_vals   = 2'b11;
    tick();
    commit_store_vals = '0;
    ld_fwd_valid = 1'b1;
    ld_fwd_addr  = 32'h202;
    #1;
    n_cmp++; if (ld_fwd_hit !== 1'b1 || ld_fwd_data !== 32'h22222222 || ld_fwd_conflict !== 1'b0) begin
      n_bad++; $display("FAIL fwd_hit: got %b %h %b want 1 22222222 0", ld_fwd_hit, ld_fwd_data, ld_fwd_conflict); end
    alloc(2'b01, 6'd3, 6'd0);
    st_exec_valid       = 1'b1;
    st_exec_rob_tag     = 6'd3;
    st_exec_addr        = 32'h201;
    st_exec_data        = 32'h33333333;
    st_exec_be          = 4'h3;
    commit_store_ids[0] = 6'd3;
    commit_store_vals   = 2'b01;
    tick();
    st_exec_valid     = 1'b0;
    commit_store_vals = '0;
    #1;
    n_cmp++; if (ld_fwd_conflict !== 1'b1 || ld_fwd_hit !== 1'b0) begin
      n_bad++; $display("FAIL fwd_conflict: got conflict %b hit %b want 1 0", ld_fwd_conflict, ld_fwd_hit); end
    ld_fwd_valid = 1'b0;
    #1;
    n_cmp++; if (ld_fwd_hit !== 1'b0 || ld_fwd_conflict !== 1'b0 || ld_fwd_data !== 32'h0) begin
      n_bad++; $display("FAIL fwd_idle: got %b %b %h want 0 0 0", ld_fwd_hit, ld_fwd_conflict, ld_fwd_data); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_drain_in_order();
    test_full_wrap();
    test_flush_and_stale();
    test_backpressure();
    test_reset_mid_drain();
`ifdef STORE_BUFFER_FWD_EN
    test_forward();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

In-order store queue between dispatch/execute and data memory. The block:
- allocates one entry per dispatched store, tagged with its ROB tag;
- captures address, data and byte-enables from the store AGU;
- marks entries committed when the ROB retires them through `commit_store_ids`/`commit_store_vals`;
- drains committed stores to the data-memory port one per cycle, in program order.

On `flush`, uncommitted entries are discarded and committed entries keep draining.

## Interface
- `SQ_DEPTH`, 8: entries; power of two, ≥4. `SQ_IDX = $clog2(SQ_DEPTH)`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  ROB redirect; discard uncommitted entries.
- `sq_alloc_req`  in  `PIPE_WIDTH`  per-slot store allocation request (slot 0 older).
- `sq_alloc_rob_tags`  in  `PIPE_WIDTH`×`TAG_WIDTH`  ROB tag per slot.
- `sq_rdy`  out  2  bit0: ≥1 free entry; bit1: ≥2 free entries.
- `sq_alloc_ids`  out  `PIPE_WIDTH`×`SQ_IDX`  indices the next allocation will use (tail, tail+1 compacted).
- `st_exec_valid`  in  1  AGU result valid.
- `st_exec_rob_tag`  in  `TAG_WIDTH`  tag of the resolving store.
- `st_exec_addr`  in  `CPU_ADDR_BITS`  byte address.
- `st_exec_data`  in  `CPU_DATA_BITS`  store data, lane-aligned.
- `st_exec_be`  in  4  byte enables.
- `commit_store_ids`  in  `PIPE_WIDTH`×`TAG_WIDTH`  from ROB.
- `commit_store_vals`  in  `PIPE_WIDTH`  from ROB; bit0 older.
- `dmem_req_valid`  out  1  drain request.
- `dmem_req_addr`  out  `CPU_ADDR_BITS`  word-aligned address (`addr[1:0]` = 0).
- `dmem_req_data`  out  `CPU_DATA_BITS`  data.
- `dmem_req_be`  out  4  byte enables.
- `dmem_req_ready`  in  1  memory accepts.
- `sq_empty`  out  1  no valid entries.
- `sq_count`  out  `SQ_IDX`+1  occupancy.

## Operation
- **Pointers:** `head` (oldest), `cmt` (first uncommitted), `tail` (next free). Each is `SQ_IDX`+1 bits; the MSB is the wrap bit.
  - count = `tail` − `head`.
  - full when count == `SQ_DEPTH`.
- **Entry state:** FREE → ALLOC (tag known) → RESOLVED (addr/data/be captured) → COMMITTED → FREE (on drain handshake).
  - The `resolved` and `committed` flags are independent.
  - Drain requires both flags set.
- **Allocation:**
  - Request bits are compacted: slot 0 takes `tail`, slot 1 takes the next index.
  - A slot is accepted only if space allows. `sq_rdy` covers this; requesting beyond `sq_rdy` is a protocol error and the request is dropped.
  - `tail` advances by the number accepted (0–2).
- **Resolve:**
  - On `st_exec_valid`, a CAM match of `st_exec_rob_tag` against ALLOC entries in [`cmt`, `tail`) captures the payload.
  - No match: ignored (stale after flush).
- **Commit:**
  - `commit_store_vals[0]` must match the entry at `cmt`.
  - `commit_store_vals[1]` must match the entry at `cmt`+`commit_store_vals[0]`.
  - A tag mismatch fires an assertion; the entry is committed anyway.
  - `cmt` advances by 0–2.
- **Drain:** `dmem_req_*` are driven combinationally from the registered head entry. `head` advances on `dmem_req_valid` & `dmem_req_ready`.
- **Flush:**
  - Commit and resolve in the same cycle are applied first.
  - Then `tail` ← new `cmt`; FREE-mark [new `cmt`, old `tail`).
  - Allocation in the flush cycle is ignored.
- **Wrap-around:** index = pointer[`SQ_IDX`-1:0]; full/empty are distinguished by the wrap bit.

## Timing
- **Reset:**
  - All pointers and flags are 0.
  - `sq_rdy` = 2'b11, `sq_empty` = 1, `sq_count` = 0.
  - `dmem_req_valid` = 0; `dmem_req_addr`, `dmem_req_data`, `dmem_req_be` = 0.
  - `sq_alloc_ids` = {1, 0}.
  - Reset mid-drain drops the request with no handshake.
- **Registered outputs:** `sq_rdy`, `sq_count` and `sq_empty` derive from registered pointers and update the cycle after alloc/drain/flush.
- **Latencies:**
  - Alloc → resolvable: next cycle.
  - Commit → `dmem_req_valid`: 1 cycle, if resolved and at head.
  - Drain throughput: 1 store/cycle while `dmem_req_ready` is held high.
- **Simultaneous alloc and drain at full:**
  - `sq_rdy` reflects the pre-drain count.
  - The freed slot is offered the next cycle.
- **Simultaneous resolve and commit of the same entry:** both flags are set; the entry is drainable next cycle.

## Configuration
- `STORE_BUFFER_FWD_EN` defined: adds the following ports.
  - Inputs: `ld_fwd_valid` 1, `ld_fwd_addr` `CPU_ADDR_BITS`.
  - Outputs: `ld_fwd_hit` 1, `ld_fwd_data` `CPU_DATA_BITS`, `ld_fwd_conflict` 1.
- Only COMMITTED entries are searched; these are always older than any in-flight load.
- Search is a word-address compare; the youngest matching entry wins.
- Youngest matching entry has be == 4'hF: `ld_fwd_hit` = 1 and `ld_fwd_data` = its data.
- Youngest matching entry has any other be: `ld_fwd_conflict` = 1 and `ld_fwd_hit` = 0.
- All three outputs are combinational and 0 when `ld_fwd_valid` = 0.
- Not defined: the ports and search logic are absent.

## Structure
- `uarch_pkg` gains:
  - `SQ_DEPTH` default;
  - `sq_entry_t` {rob_tag, addr, data, be, resolved, committed, valid};
  - `dmem_store_req_t` {valid, addr, data, be}.
- One sub-module, `sq_tag_cam`: tag match over the entry array, returning a one-hot hit vector. It is used for resolve.

## Test plan
- **Drain in order:**
  - Stimulus: alloc tags 3,4; resolve tag 4 (0x104, 0xBBBBBBBB, be F), then tag 3 (0x100, 0xAAAAAAAA); commit {3,4} with `dmem_req_ready` = 1.
  - Response: 0x100/0xAAAAAAAA drains, then 0x104/0xBBBBBBBB on consecutive cycles; `sq_empty` = 1 after.
- **Full/wrap:**
  - Stimulus: 8 allocs; then drain 2 and alloc 2.
  - Response: after the 8 allocs, `sq_rdy` = 00 and `sq_count` = 8. After drain and alloc, `tail` index wraps to 2 and `sq_count` = 8.
- **Flush:**
  - Stimulus: 4 entries allocated; commit the first 1 in the same cycle as `flush`.
  - Response: `sq_count` = 1 next cycle; only that store drains.
- **Backpressure:**
  - Stimulus: committed head, `dmem_req_ready` = 0 for 3 cycles.
  - Response: `dmem_req_valid` = 1 and payload stable throughout; `head` unchanged.
- **Stale resolve:**
  - Stimulus: resolve with a tag flushed the prior cycle.
  - Response: no state change.
- **`STORE_BUFFER_FWD_EN` (forwarding):**
  - Stimulus: committed stores to 0x200 (be F, 0x11111111), then 0x200 (be F, 0x22222222); load from 0x202.
  - Response: `ld_fwd_hit` = 1, `ld_fwd_data` = 0x22222222.
  - A younger committed be 4'h3 store to the same word → `ld_fwd_conflict` = 1.
